alu_issue: RTL and testbench

- Issue/capture front end for the combinational ALU: the producer of its operands and control, and the consumer of its result and zero flag.
- Accepts a decoded-in-place RV32 instruction plus register operands over a valid/ready handshake.
- Decodes it to an ALU op, drives the ALU from a registered issue stage, and captures the result and branch decision into an output stage with its own valid/ready.
- Sits between register read and writeback/branch resolution.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_decoder.sv | 48 ++++
 rtl/alu_issue.sv | 127 ++++++++++++
 tb/tb_alu_issue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encoding, RV32 decode constants and issue-stage record.
package alu_pkg;

    localparam int AluXLen = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    // Branches resolve on the zero flag alone: BEQ/BGE take on zero, BNE/BLT on non-zero.
    typedef enum logic [1:0] {
        BR_NONE  = 2'd0,
        BR_ZERO  = 2'd1,
        BR_NZERO = 2'd2
    } br_kind_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef struct packed {
        logic [AluXLen-1:0] a;
        logic [AluXLen-1:0] b;
        alu_op_e            op;
        br_kind_e           br_kind;
        logic               illegal;
    } s1_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational RV32 OP/OP-IMM/BRANCH decode to ALU op, operand-B source and branch kind.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0]        instr_i,
    output alu_op_e            op_o,
    output logic               use_imm_o,
    output logic [AluXLen-1:0] imm_o,
    output br_kind_e           br_kind_o,
    output logic               illegal_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic       arith_ok;
    logic       br_ok;
    alu_op_e    arith_op;
    logic       unused_fields;

    assign opc           = instr_i[6:0];
    assign f3            = instr_i[14:12];
    assign arith_ok      = f3 inside {F3_ADD, F3_AND, F3_OR, F3_SLT};
    assign br_ok         = f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
    assign arith_op      = f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : f3 == F3_SLT ? ALU_SLT : ALU_ADD;
    assign imm_o         = {{(AluXLen-12){instr_i[31]}}, instr_i[31:20]};
    assign unused_fields = ^{instr_i[19:15], instr_i[11:7]};

    // Anything outside the three supported opcode/funct3 groups decodes as illegal ADD.
    always_comb begin
        op_o      = ALU_ADD;
        use_imm_o = 1'b0;
        br_kind_o = BR_NONE;
        illegal_o = 1'b1;
        if (opc == OPC_OP && arith_ok) begin
            illegal_o = 1'b0;
            op_o      = (f3 == F3_ADD && instr_i[30]) ? ALU_SUB : arith_op;
        end else if (opc == OPC_OP_IMM && arith_ok) begin
            illegal_o = 1'b0;
            op_o      = arith_op;
            use_imm_o = 1'b1;
        end else if (opc == OPC_BRANCH && br_ok) begin
            illegal_o = 1'b0;
            op_o      = (f3 == F3_BEQ || f3 == F3_BNE) ? ALU_SUB : ALU_SLT;
            br_kind_o = (f3 == F3_BEQ || f3 == F3_BGE) ? BR_ZERO : BR_NZERO;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/capture front end around an external combinational ALU.
// Define ALU_ISSUE_PERF_EN to add retired-result and input-stall counters.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLen = AluXLen,
    parameter int NOps = 5,
    localparam int NOpsWidth = $clog2(NOps)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [XLen-1:0]      rs1_data_i,
    input  logic [XLen-1:0]      rs2_data_i,
    output logic [XLen-1:0]      alu_a_o,
    output logic [XLen-1:0]      alu_b_o,
    output logic [NOpsWidth-1:0] alu_control_o,
    input  logic [XLen-1:0]      alu_result_i,
    input  logic                 alu_zero_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLen-1:0]      out_result_o,
    output logic                 out_branch_taken_o,
    output logic                 out_illegal_o
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]          perf_retired_o,
    output logic [31:0]          perf_stall_o
`endif
);

    alu_op_e             dec_op;
    logic                dec_use_imm;
    logic [AluXLen-1:0]  dec_imm;
    br_kind_e            dec_br_kind;
    logic                dec_illegal;
    s1_t                 s1_d, s1_q;
    logic                s1_valid_q;
    logic                s2_valid_q;
    logic [XLen-1:0]     out_result_q;
    logic                out_taken_q;
    logic                out_illegal_q;
    logic                s1_advance;
    logic                accept;
    logic                taken;

    alu_decoder u_dec (
        .instr_i  (instr_i),
        .op_o     (dec_op),
        .use_imm_o(dec_use_imm),
        .imm_o    (dec_imm),
        .br_kind_o(dec_br_kind),
        .illegal_o(dec_illegal)
    );

    assign s1_advance = !s2_valid_q || out_ready_i;
    assign in_ready_o = !s1_valid_q || s1_advance;
    assign accept     = in_valid_i && in_ready_o;

    // Illegal encodings issue as 0+0 so a clean zero result still flows downstream.
    always_comb begin
        s1_d.a       = dec_illegal ? '0 : rs1_data_i;
        s1_d.b       = dec_illegal ? '0 : dec_use_imm ? dec_imm : rs2_data_i;
        s1_d.op      = dec_op;
        s1_d.br_kind = dec_br_kind;
        s1_d.illegal = dec_illegal;
    end

    assign taken = s1_q.br_kind == BR_ZERO ? alu_zero_i : s1_q.br_kind == BR_NZERO ? !alu_zero_i : 1'b0;

    // Issue stage: holds the ALU operands until the capture stage can take the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            if (accept) s1_q <= s1_d;
            s1_valid_q <= accept || (s1_valid_q && !s1_advance);
        end
    end

    // Capture stage: latches ALU result and branch decision, held under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q    <= 1'b0;
            out_result_q  <= '0;
            out_taken_q   <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (s1_valid_q && s1_advance) begin
            s2_valid_q    <= 1'b1;
            out_result_q  <= alu_result_i;
            out_taken_q   <= taken;
            out_illegal_q <= s1_q.illegal;
        end else if (out_ready_i) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign alu_a_o            = s1_q.a;
    assign alu_b_o            = s1_q.b;
    assign alu_control_o      = NOpsWidth'(s1_q.op);
    assign out_valid_o        = s2_valid_q;
    assign out_result_o       = out_result_q;
    assign out_branch_taken_o = out_taken_q;
    assign out_illegal_o      = out_illegal_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] retired_q, stall_q;

    // Free-running wrap-around counters of completed outputs and stalled input cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (out_valid_o && out_ready_i) retired_q <= retired_q + 32'd1;
            if (in_valid_i && !in_ready_o) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_retired_o = retired_q;
    assign perf_stall_o   = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a behavioural ALU in the loop.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_control;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_taken, out_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_retired, perf_stall;
`endif

    typedef struct {
        logic [31:0] res;
        logic        taken;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_control)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = alu_result == '0;

    alu_issue dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .in_valid_i        (in_valid),
        .in_ready_o        (in_ready),
        .instr_i           (instr),
        .rs1_data_i        (rs1),
        .rs2_data_i        (rs2),
        .alu_a_o           (alu_a),
        .alu_b_o           (alu_b),
        .alu_control_o     (alu_control),
        .alu_result_i      (alu_result),
        .alu_zero_i        (alu_zero),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_result_o      (out_result),
        .out_branch_taken_o(out_taken),
        .out_illegal_o     (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_retired_o    (perf_retired),
        .perf_stall_o      (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    function automatic logic [31:0] b_ins(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    // Present one instruction, wait (bounded) for acceptance, queue the expected output
    // and check the issue-stage operands right after the accepting edge.
    task automatic send(input string name, input logic [31:0] ins, input logic [31:0] a_in,
                        input logic [31:0] b_in, input logic [31:0] exp_a, input logic [31:0] exp_b,
                        input logic [2:0] exp_op, input logic [31:0] exp_res, input logic exp_taken,
                        input logic exp_ill);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        instr    = ins;
        rs1      = a_in;
        rs2      = b_in;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            e.res   = exp_res;
            e.taken = exp_taken;
            e.ill   = exp_ill;
            q.push_back(e);
            @(posedge clk);
            #1;
            chk({name, "_alu_a"}, alu_a, exp_a);
            chk({name, "_alu_b"}, alu_b, exp_b);
            chk({name, "_alu_op"}, {29'd0, alu_control}, {29'd0, exp_op});
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_result", out_result, e.res);
                chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
                chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", {29'd0, alu_control}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        @(posedge clk);
        #1;

        send("add", r_ins(7'h00, 3'b000), 32'd5, 32'd7, 32'd5, 32'd7, 3'd0, 32'd12, 1'b0, 1'b0);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        drain();

        send("sub", r_ins(7'h20, 3'b000), 32'd10, 32'd3, 32'd10, 32'd3, 3'd1, 32'd7, 1'b0, 1'b0);
        send("and", r_ins(7'h00, 3'b111), 32'hF0F0, 32'hFF00, 32'hF0F0, 32'hFF00, 3'd2, 32'hF000, 1'b0, 1'b0);
        send("or", r_ins(7'h00, 3'b110), 32'hF0F0, 32'hFF00, 32'hF0F0, 32'hFF00, 3'd3, 32'hFFF0, 1'b0, 1'b0);
        send("slt", r_ins(7'h00, 3'b010), 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFE, 32'd1, 3'd4, 32'd1, 1'b0, 1'b0);
        send("addi", i_ins(12'hFFF, 3'b000), 32'd3, 32'd99, 32'd3, 32'hFFFFFFFF, 3'd0, 32'd2, 1'b0, 1'b0);
        send("andi", i_ins(12'h0FF, 3'b111), 32'h1234, 32'd99, 32'h1234, 32'h000000FF, 3'd2, 32'h34, 1'b0, 1'b0);
        send("beq", b_ins(3'b000), 32'd9, 32'd9, 32'd9, 32'd9, 3'd1, 32'd0, 1'b1, 1'b0);
        send("bne", b_ins(3'b001), 32'd9, 32'd9, 32'd9, 32'd9, 3'd1, 32'd0, 1'b0, 1'b0);
        send("blt", b_ins(3'b100), 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFE, 32'd1, 3'd4, 32'd1, 1'b1, 1'b0);
        send("bge", b_ins(3'b101), 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFE, 32'd1, 3'd4, 32'd1, 1'b0, 1'b0);
        send("ill_all1", 32'hFFFFFFFF, 32'd5, 32'd7, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b1);
        send("ill_br_f3", b_ins(3'b010), 32'd5, 32'd7, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0, 1'b1);
        drain();

        out_ready = 1'b0;
        send("bp_a", r_ins(7'h00, 3'b000), 32'd1, 32'd2, 32'd1, 32'd2, 3'd0, 32'd3, 1'b0, 1'b0);
        send("bp_b", r_ins(7'h20, 3'b000), 32'd10, 32'd4, 32'd10, 32'd4, 3'd1, 32'd6, 1'b0, 1'b0);
        fork
            send("bp_c", r_ins(7'h00, 3'b110), 32'h0F, 32'hF0, 32'h0F, 32'hF0, 3'd3, 32'hFF, 1'b0, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("bp_hold_result", out_result, 32'd3);
                    chk("bp_hold_alu_a", alu_a, 32'd10);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send("rst_x", r_ins(7'h00, 3'b000), 32'd4, 32'd4, 32'd4, 32'd4, 3'd0, 32'd8, 1'b0, 1'b0);
        send("rst_y", r_ins(7'h00, 3'b111), 32'd6, 32'd3, 32'd6, 32'd3, 3'd2, 32'd2, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_alu_op", {29'd0, alu_control}, 32'd0);
        chk("post_rst_result", out_result, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("post_rst_perf_retired", perf_retired, 32'd0);
        chk("post_rst_perf_stall", perf_stall, 32'd0);
`endif
        @(posedge clk);
        #1;
        send("after_rst", r_ins(7'h00, 3'b000), 32'd20, 32'd22, 32'd20, 32'd22, 3'd0, 32'd42, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
